pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//   Consumer/driver side of the PC register: reads PC value, fetches the instruction at that address
//   over a req/ack instruction-memory port, buffers it for decode, and drives the PC load interface
//   (LD + datain) with PC+4 or a redirect target. Sits between PC, instruction memory and decode.
// PARAMETERS
//   ADDR_W   32  PC / memory address width
//   INSTR_W  32  instruction word width
//   PC_STEP  4   sequential increment in bytes
// PORTS
//   clk              in   1        single clock, all state on rising edge
//   reset            in   1        asynchronous, active-low; clears all state immediately
//   pc_in            in   ADDR_W   current PC value (PC dataout)
//   pc_ld            out  1        PC load strobe (to PC LD); combinational from state/inputs
//   pc_next          out  ADDR_W   PC load value (to PC datain)
//   imem_req         out  1        fetch request; held with stable imem_addr until imem_ack
//   imem_addr        out  ADDR_W   fetch address
//   imem_ack         in   1        response valid; may be same cycle as req rise
//   imem_rdata       in   INSTR_W  instruction word, valid with imem_ack
//   redirect         in   1        branch/jump taken; one-cycle pulse
//   redirect_target  in   ADDR_W   new PC, sampled with redirect
//   instr_valid      out  1        buffered instruction valid to decode
//   instr            out  INSTR_W  buffered instruction
//   instr_pc         out  ADDR_W   address of buffered instruction
//   instr_ready      in   1        decode accepts (transfer = instr_valid & instr_ready)
// BEHAVIOUR
//   - Reset values: state IDLE, instr_valid 0, instr 0, instr_pc 0, req_addr 0; hence imem_req 0,
//     imem_addr 0, pc_ld 0, pc_next 0. reset held low >=1 clk edge so PC holds its initial value.
//   - States: IDLE, FETCH, DISCARD. IDLE -> FETCH unconditionally on first edge after reset release.
//   - slot_free = !instr_valid | instr_ready. FETCH: imem_req = slot_free, imem_addr = pc_in;
//     req_addr <= pc_in each req cycle. Once req rises buffer is empty, so req stays high to ack.
//   - FETCH & req & ack & !redirect: instr<=imem_rdata, instr_pc<=pc_in, instr_valid<=1; same cycle
//     pc_ld=1, pc_next=pc_in+PC_STEP (mod 2^ADDR_W, 0xFFFFFFFC wraps to 0). Stay FETCH.
//     With single-cycle ack and instr_ready=1: one instruction per cycle.
//   - Transfer without new ack: instr_valid<=0.
//   - redirect (priority over everything except reset; ignored in IDLE): pc_ld=1,
//     pc_next={redirect_target[ADDR_W-1:2],2'b00} (misaligned targets forced aligned); instr_valid<=0
//     (buffered instr flushed, even if instr_ready same cycle). Transitions:
//       FETCH, req & !ack -> DISCARD (request outstanding, response stale)
//       FETCH, req & ack  -> FETCH, response dropped, buffer not written
//       FETCH, !req       -> FETCH
//       DISCARD           -> DISCARD (newer target overwrites PC; old request still pending)
//   - DISCARD: imem_req=1, imem_addr=req_addr (original address, stable); on imem_ack data dropped,
//     no pc_ld, -> FETCH. Next request uses pc_in = redirect target.
//   - pc_ld never asserted except on accepted ack in FETCH or redirect; PC otherwise holds.
//   - Reset mid-request: req drops asynchronously; memory must abandon outstanding access.
//   - Arithmetic unsigned, ADDR_W bits, carry discarded.
// STRUCTURE
//   - Package mips_fetch_pkg: fetch_state_t enum {IDLE,FETCH,DISCARD}, PC_STEP, ADDR_W/INSTR_W defaults.
//   - Sub-module fetch_buffer: 1-entry valid/ready register (instr, instr_pc, valid) with load,
//     flush, slot_free output. FSM, pc_next mux and req_addr stay in pc_fetch_ctrl.
// TESTING
//   1 reset low 3 cycles, PC=0x00400000, ack same cycle, ready=1 -> first req cycle 1 after release,
//     instr_pc 0x00400000,0x00400004,0x00400008 on consecutive cycles; pc_ld every cycle.
//   2 ack 3 cycles after req -> imem_req/imem_addr stable 3 cycles, pc_ld single pulse, pc_next=addr+4.
//   3 instr_ready=0 with instr_valid=1 -> imem_req=0, pc_ld=0, instr/instr_pc held; ready=1 resumes.
//   4 redirect to 0x00400103 while req pending at 0x00400010 -> pc_next 0x00400100, DISCARD,
//     addr stays 0x00400010, late ack data not delivered, next req at 0x00400100.
//   5 redirect same cycle as ack and instr_valid=1 -> buffer flushed, rdata dropped, pc_next=target.
//   6 PC=0xFFFFFFFC fetched -> pc_next 0x00000000; reset asserted mid-request -> all outputs 0 async.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg
//   Shared definitions for the instruction fetch controller.
//   - fetch_state_t : controller state encoding (IDLE, FETCH, DISCARD)
//   - DEF_ADDR_W    : default PC / memory address width
//   - DEF_INSTR_W   : default instruction word width
//   - DEF_PC_STEP   : default sequential PC increment in bytes
package mips_fetch_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   One-entry valid/ready holding register between instruction memory and
//   decode. Holds an instruction word together with the address it came from.
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low clear
//   load       in   capture load_instr/load_pc and mark the entry valid
//   flush      in   drop the entry; wins over load and over a transfer
//   load_instr in   instruction word to capture
//   load_pc    in   address of the word to capture
//   ready      in   downstream accepts the entry this cycle
//   valid      out  entry holds an instruction
//   instr      out  buffered instruction word
//   instr_pc   out  address of the buffered instruction
//   slot_free  out  entry is empty or is being drained this cycle
module fetch_buffer
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  input  logic               ready,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               slot_free
);

  logic               valid_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  instr_pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg    <= 1'b0;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else begin
      if (flush) begin
        // A redirect makes the held word wrong-path even if decode is
        // taking it this cycle, so flush takes precedence.
        valid_reg <= 1'b0;
      end else if (load) begin
        valid_reg    <= 1'b1;
        instr_reg    <= load_instr;
        instr_pc_reg <= load_pc;
      end else if (ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign valid     = valid_reg;
  assign instr     = instr_reg;
  assign instr_pc  = instr_pc_reg;
  assign slot_free = !valid_reg || ready;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Fetch controller sitting between the PC register, instruction memory and
//   decode. Fetches the word at the current PC, hands it to decode through a
//   one-entry buffer, and loads the PC with PC+PC_STEP or a redirect target.
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous, active-low clear
//   pc_in           in   current PC value
//   pc_ld           out  PC load strobe
//   pc_next         out  PC load value
//   imem_req        out  fetch request, held with a stable address until ack
//   imem_addr       out  fetch address
//   imem_ack        in   fetch response valid (may coincide with req rise)
//   imem_rdata      in   instruction word, valid with imem_ack
//   redirect        in   taken branch/jump pulse
//   redirect_target in   new PC, sampled with redirect
//   instr_valid     out  buffered instruction valid to decode
//   instr           out  buffered instruction
//   instr_pc        out  address of buffered instruction
//   instr_ready     in   decode accepts the buffered instruction
module pc_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_ld,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] req_addr_reg;

  logic              buf_load;
  logic              buf_flush;
  logic              slot_free;
  logic              req_capture;
  logic [ADDR_W-1:0] target_aligned;

  // Word-align redirect targets by clearing the two low bits.
  assign target_aligned = redirect_target & ~ALIGN_MASK;

  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .load       (buf_load),
    .flush      (buf_flush),
    .load_instr (imem_rdata),
    .load_pc    (pc_in),
    .ready      (instr_ready),
    .valid      (instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .slot_free  (slot_free)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      req_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (req_capture) begin
        req_addr_reg <= pc_in;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    imem_req    = 1'b0;
    imem_addr   = req_addr_reg;
    pc_ld       = 1'b0;
    pc_next     = '0;
    buf_load    = 1'b0;
    buf_flush   = 1'b0;
    req_capture = 1'b0;

    case (state_reg)
      IDLE: begin
        // Gives the PC one cycle to settle after reset; redirects ignored.
        state_next = FETCH;
      end

      FETCH: begin
        // A request is only issued into an empty (or draining) buffer, so
        // once raised it can stay high until ack without back-pressure.
        imem_req    = slot_free;
        imem_addr   = pc_in;
        req_capture = slot_free;
        if (redirect) begin
          pc_ld     = 1'b1;
          pc_next   = target_aligned;
          buf_flush = 1'b1;
          // An unanswered request is still in flight at memory; its reply
          // belongs to the old path and must be swallowed in DISCARD.
          if (slot_free && !imem_ack) begin
            state_next = DISCARD;
          end
        end else if (slot_free && imem_ack) begin
          buf_load = 1'b1;
          pc_ld    = 1'b1;
          pc_next  = pc_in + STEP;
        end
      end

      DISCARD: begin
        // Keep the original request asserted with its original address
        // until memory answers; the answer is dropped.
        imem_req  = 1'b1;
        imem_addr = req_addr_reg;
        if (redirect) begin
          pc_ld     = 1'b1;
          pc_next   = target_aligned;
          buf_flush = 1'b1;
        end else if (imem_ack) begin
          state_next = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_ld;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.ADDR_W(32), .INSTR_W(32), .PC_STEP(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .pc_ld           (pc_ld),
    .pc_next         (pc_next),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  // Memory contents: a fixed scramble of the address so every word differs.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // PC register environment.
  logic [31:0] pc_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= 32'h0040_0000;
    else if (pc_ld) pc_q <= pc_next;
  end
  assign pc_in = pc_q;

  // Instruction memory: acks after eff_lat waiting cycles (0 = same cycle).
  int lat_fixed = 0;
  int rand_lat;
  int mem_cnt;
  int eff_lat;
  assign eff_lat    = (lat_fixed < 0) ? rand_lat : lat_fixed;
  assign imem_ack   = imem_req && (mem_cnt >= eff_lat);
  assign imem_rdata = memf(imem_addr);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_cnt  <= 0;
      rand_lat <= 0;
    end else if (imem_req) begin
      if (imem_ack) begin
        mem_cnt  <= 0;
        rand_lat <= int'($urandom_range(3, 0));
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the architectural instruction stream decode should see.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;
  item_t exp_q[$];

  task automatic rebase(input logic [31:0] start);
    logic [31:0] a;
    exp_q.delete();
    a = start - (start % 4);
    for (int i = 0; i < 1024; i++) begin
      exp_q.push_back('{pc: a, ins: memf(a)});
      a = a + 32'd4;
    end
  endtask

  // Monitor: pops on every accepted transfer and checks handshake rules.
  logic        p_valid, p_ready, p_redir, p_req, p_ack;
  logic [31:0] p_instr, p_ipc, p_addr;

  always @(negedge clk) begin
    if (!reset) begin
      p_valid <= 1'b0;
      p_req   <= 1'b0;
    end else begin
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          check("stream_underrun", 32'd1, 32'd0);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          check("xfer_pc", instr_pc, it.pc);
          check("xfer_instr", instr, it.ins);
          $display("xfer %0d: pc=%h instr=%h", xfers, instr_pc, instr);
          xfers++;
        end
      end
      if (instr_valid && !instr_ready)
        check("req_while_full", {31'd0, imem_req}, 32'd0);
      if (p_req && !p_ack) begin
        check("req_held", {31'd0, imem_req}, 32'd1);
        check("addr_stable", imem_addr, p_addr);
      end
      if (p_valid && !p_ready && !p_redir) begin
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", instr, p_instr);
        check("hold_pc", instr_pc, p_ipc);
      end
      if (pc_ld && !redirect) begin
        check("ld_needs_ack", {31'd0, imem_ack && imem_req}, 32'd1);
        check("ld_seq_value", pc_next, imem_addr + 32'd4);
      end
      p_valid <= instr_valid;
      p_ready <= instr_ready;
      p_redir <= redirect;
      p_req   <= imem_req;
      p_ack   <= imem_ack;
      p_addr  <= imem_addr;
      p_instr <= instr;
      p_ipc   <= instr_pc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect        = 1'b1;
    redirect_target = t;
    rebase(t);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pc_ld"}, {31'd0, pc_ld}, 32'd0);
    check({tag, "_pc_next"}, pc_next, 32'd0);
    check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    check({tag, "_addr"}, imem_addr, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_ipc"}, instr_pc, 32'd0);
  endtask

  initial begin
    logic        found;
    logic [31:0] a0;

    reset           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    instr_ready     = 1'b1;
    lat_fixed       = 0;

    // 1: reset values, then one instruction per cycle.
    repeat (3) step();
    @(negedge clk);
    check_all_zero("reset");
    step();
    reset = 1'b1;
    rebase(32'h0040_0000);
    @(negedge clk);
    check("idle_req", {31'd0, imem_req}, 32'd0);
    check("idle_ld", {31'd0, pc_ld}, 32'd0);
    step();
    @(negedge clk);
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0040_0000);
    check("first_ld", {31'd0, pc_ld}, 32'd1);
    check("first_next", pc_next, 32'h0040_0004);
    step();
    @(negedge clk);
    check("second_addr", imem_addr, 32'h0040_0004);
    check("second_ld", {31'd0, pc_ld}, 32'd1);
    check("second_valid", {31'd0, instr_valid}, 32'd1);
    check("second_ipc", instr_pc, 32'h0040_0000);
    repeat (3) step();

    // 2: three-cycle ack latency.
    lat_fixed = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_ack) found = 1'b1;
    end
    check("wait_ack", {31'd0, found}, 32'd1);
    step();
    @(negedge clk);
    a0 = imem_addr;
    check("lat_req", {31'd0, imem_req}, 32'd1);
    check("lat_ld0", {31'd0, pc_ld}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      @(negedge clk);
      check("lat_req_held", {31'd0, imem_req}, 32'd1);
      check("lat_addr_held", imem_addr, a0);
      check("lat_ld", {31'd0, pc_ld}, (k == 3) ? 32'd1 : 32'd0);
    end
    check("lat_next", pc_next, a0 + 32'd4);

    // 3: decode stalls with a full buffer.
    lat_fixed = 0;
    repeat (3) step();
    instr_ready = 1'b0;
    @(negedge clk);
    check("stall_valid", {31'd0, instr_valid}, 32'd1);
    check("stall_req", {31'd0, imem_req}, 32'd0);
    check("stall_ld", {31'd0, pc_ld}, 32'd0);
    step();
    @(negedge clk);
    check("stall2_ld", {31'd0, pc_ld}, 32'd0);
    step();
    instr_ready = 1'b1;
    @(negedge clk);
    check("resume_ld", {31'd0, pc_ld}, 32'd1);

    // 4: redirect while a request is pending -> late data swallowed.
    lat_fixed = 3;
    step();
    do_redirect(32'h0040_0010);
    step();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h0040_0010) found = 1'b1;
    end
    check("wait_addr_10", {31'd0, found}, 32'd1);
    step();
    do_redirect(32'h0040_0103);
    @(negedge clk);
    check("redir_ld", {31'd0, pc_ld}, 32'd1);
    check("redir_next", pc_next, 32'h0040_0100);
    check("redir_pending_addr", imem_addr, 32'h0040_0010);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("discard_req", {31'd0, imem_req}, 32'd1);
    check("discard_addr", imem_addr, 32'h0040_0010);
    check("discard_ld", {31'd0, pc_ld}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 32'h0040_0100) found = 1'b1;
    end
    check("req_at_target", {31'd0, found}, 32'd1);

    // 5: redirect in the same cycle as an ack with a full buffer.
    lat_fixed = 0;
    repeat (4) step();
    do_redirect(32'h0040_0200);
    @(negedge clk);
    check("flush_valid_before", {31'd0, instr_valid}, 32'd1);
    check("flush_ack", {31'd0, imem_ack}, 32'd1);
    check("flush_ld", {31'd0, pc_ld}, 32'd1);
    check("flush_next", pc_next, 32'h0040_0200);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("flush_valid_after", {31'd0, instr_valid}, 32'd0);
    check("flush_new_addr", imem_addr, 32'h0040_0200);

    // 6: PC wrap, then reset in the middle of a request.
    repeat (3) step();
    do_redirect(32'hFFFF_FFFC);
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_ld", {31'd0, pc_ld}, 32'd1);
    check("wrap_next", pc_next, 32'h0000_0000);
    step();
    @(negedge clk);
    check("wrap_addr0", imem_addr, 32'h0000_0000);
    lat_fixed = 3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req && !imem_ack) found = 1'b1;
    end
    check("wait_pending", {31'd0, found}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) step();
    reset = 1'b1;
    rebase(32'h0040_0000);

    // Randomized traffic.
    lat_fixed = -1;
    for (int c = 0; c < 3000; c++) begin
      step();
      redirect    = 1'b0;
      instr_ready = ($urandom_range(3, 0) != 0);
      if (c > 2 && $urandom_range(19, 0) == 0) begin
        if ($urandom_range(7, 0) == 0)
          do_redirect(32'hFFFF_FFF0 + 32'($urandom_range(15, 0)));
        else
          do_redirect(32'h0040_0000 + 32'($urandom_range(4095, 0)));
      end
    end
    step();
    redirect = 1'b0;
    repeat (5) step();
    check("progress", {31'd0, xfers >= 500}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
